// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM states, requester identity
// and the width of the access watchdog counter.
package lc3_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } ArbStates;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } ArbOwner;

  localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single LC-3 memory port between the CPU
// (MAR/MDR side) and a DMA requester. One access is in flight at a time; a
// watchdog aborts accesses whose memory never acknowledges, returning zero
// data and flagging timeout_err alongside the requester's rdy pulse.
module lc3_mem_arbiter
  import lc3_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_rdy,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          timeout_err
);

  // Terminal count: the access is abandoned in the ACCESS cycle where the
  // counter holds this value and memory still has not acknowledged.
  localparam logic [ARB_CNT_W-1:0] TERM_CNT = ARB_CNT_W'(TIMEOUT_CYC - 1);

  ArbStates             state, nextState;
  ArbOwner              owner, lastGrant, grantOwner;
  logic                 grantValid, ackDone, timeoutHit, abortFlag;
  logic [ARB_CNT_W-1:0] waitCount;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= nextState;
  end

  // Next-state logic: round-robin grant, ack completion and watchdog abort.
  always_comb begin
    nextState  = state;
    grantValid = 1'b0;
    grantOwner = OWN_CPU;
    ackDone    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (cpu_req && dma_req) begin
          grantValid = 1'b1;
          grantOwner = (lastGrant == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (cpu_req) begin
          grantValid = 1'b1;
          grantOwner = OWN_CPU;
        end else if (dma_req) begin
          grantValid = 1'b1;
          grantOwner = OWN_DMA;
        end
        if (grantValid) nextState = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (mem_ack) begin
          ackDone   = 1'b1;
          nextState = ARB_DONE;
        end else if (waitCount == TERM_CNT) begin
          timeoutHit = 1'b1;
          nextState  = ARB_DONE;
        end
      end
      ARB_DONE: nextState = ARB_IDLE;
      default:  nextState = ARB_IDLE;
    endcase
  end

  // Access registers, grant history, watchdog counter and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_CPU;
      lastGrant <= OWN_DMA;
      waitCount <= '0;
      abortFlag <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (grantValid) begin
        owner     <= grantOwner;
        lastGrant <= grantOwner;
        waitCount <= '0;
        abortFlag <= 1'b0;
        mem_we    <= (grantOwner == OWN_DMA) ? dma_we    : cpu_we;
        mem_addr  <= (grantOwner == OWN_DMA) ? dma_addr  : cpu_addr;
        mem_wdata <= (grantOwner == OWN_DMA) ? dma_wdata : cpu_wdata;
      end
      if (state == ARB_ACCESS && !ackDone && !timeoutHit) begin
        waitCount <= waitCount + 1'b1;
      end
      if (ackDone && !mem_we) begin
        if (owner == OWN_DMA) dma_rdata <= mem_rdata;
        else                  cpu_rdata <= mem_rdata;
      end
      if (timeoutHit) begin
        abortFlag <= 1'b1;
        if (owner == OWN_DMA) dma_rdata <= '0;
        else                  cpu_rdata <= '0;
      end
    end
  end

  // Outputs decoded from state so reset drops them immediately.
  always_comb begin
    mem_en      = (state == ARB_ACCESS);
    busy        = (state == ARB_ACCESS) || (state == ARB_DONE);
    cpu_rdy     = (state == ARB_DONE) && (owner == OWN_CPU);
    dma_rdy     = (state == ARB_DONE) && (owner == OWN_DMA);
    timeout_err = (state == ARB_DONE) && abortFlag;
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with an 8-cycle watchdog: a table of
// single-requester accesses plus hand-written contention and reset sequences.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_rdy;
  logic [15:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_rdy;
  logic [15:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isDma;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ackAt;
    logic [15:0] ackData;
    int          expEn;
    logic [15:0] expRdata;
    logic        expTimeout;
  } Vec;

  Vec vecs[8];

  lc3_mem_arbiter #(.TIMEOUT_CYC(8), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdy(dma_rdy), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One single-requester access; memory acks in mem_en cycle ackAt (0 = never).
  task automatic applyStimulus(input int idx, input Vec v);
    int   enCnt;
    logic gotRdy;
    string tag;
    enCnt  = 0;
    gotRdy = 1'b0;
    tag    = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.isDma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    mem_ack = 1'b0;
    for (int c = 0; c < 40 && !gotRdy; c++) begin
      @(negedge clk);
      if (cpu_rdy || dma_rdy) begin
        gotRdy = 1'b1;
        checkOutput({tag, " rdy pair"}, {30'd0, cpu_rdy, dma_rdy},
                    v.isDma ? 32'd1 : 32'd2);
        checkOutput({tag, " timeout_err"}, 32'(timeout_err), 32'(v.expTimeout));
        checkOutput({tag, " rdata"}, 32'(v.isDma ? dma_rdata : cpu_rdata),
                    32'(v.expRdata));
        checkOutput({tag, " mem_en cycles"}, 32'(enCnt), 32'(v.expEn));
        checkOutput({tag, " busy in done"}, 32'(busy), 32'd1);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        mem_ack = 1'b0;
      end else if (mem_en) begin
        enCnt++;
        if (enCnt == 1) begin
          checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
          checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
          if (v.we) checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
        end
        if (v.ackAt != 0 && enCnt == v.ackAt) begin
          mem_ack   = 1'b1;
          mem_rdata = v.ackData;
        end else begin
          mem_ack = 1'b0;
        end
      end
    end
    checkOutput({tag, " rdy seen"}, 32'(gotRdy), 32'd1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput({tag, " rdy after pulse"}, {30'd0, cpu_rdy, dma_rdy}, 32'd0);
    checkOutput({tag, " busy after pulse"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   grants;
    logic prevEn, gotRdy, anyRdy;

    vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 3, 16'h1234, 3, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h4000, 16'hBEEF, 1, 16'hDEAD, 1, 16'h2001, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h4001, 16'h0000, 2, 16'hCAFE, 2, 16'hCAFE, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h3001, 16'h5555, 1, 16'hDEAD, 1, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h3002, 16'h0000, 0, 16'h0000, 8, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h3003, 16'h0000, 8, 16'hA5A5, 8, 16'hA5A5, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h4002, 16'h0000, 7, 16'h1111, 7, 16'h1111, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h4003, 16'h7777, 0, 16'h0000, 8, 16'h0000, 1'b1};

    // Reset state
    #12;
    checkOutput("reset outputs",
                {25'd0, mem_en, mem_we, cpu_rdy, dma_rdy, busy, timeout_err, 1'b0},
                32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset rdata", {cpu_rdata, dma_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention straight after reset: CPU first, then alternate
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h2000;
    grants = 0;
    prevEn = 1'b0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      @(negedge clk);
      if (mem_en && !prevEn) begin
        checkOutput($sformatf("contention grant%0d", grants), 32'(mem_addr),
                    (grants % 2 == 0) ? 32'h1000 : 32'h2000);
        grants++;
      end
      prevEn    = mem_en;
      mem_ack   = mem_en;
      mem_rdata = mem_addr + 16'h0001;
    end
    checkOutput("contention grant count", 32'(grants), 32'd4);
    gotRdy = 1'b0;
    for (int c = 0; c < 10 && !gotRdy; c++) begin
      @(negedge clk);
      mem_ack = mem_en;
      if (dma_rdy) gotRdy = 1'b1;
    end
    checkOutput("contention last rdy", 32'(gotRdy), 32'd1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    mem_ack = 1'b0;
    checkOutput("contention cpu_rdata", 32'(cpu_rdata), 32'h1001);
    checkOutput("contention dma_rdata", 32'(dma_rdata), 32'h2001);

    // Table-driven single-requester accesses
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Reset in the second ACCESS cycle of a CPU read
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
    @(negedge clk);
    checkOutput("midreset mem_en before", 32'(mem_en), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset mem_en async", 32'(mem_en), 32'd0);
    checkOutput("midreset busy async", 32'(busy), 32'd0);
    checkOutput("midreset rdy async", {30'd0, cpu_rdy, timeout_err}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b0;
    anyRdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cpu_rdy || dma_rdy || busy) anyRdy = 1'b1;
    end
    checkOutput("midreset no rdy", 32'(anyRdy), 32'd0);

    // Tie after reset goes to the CPU again
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h6000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h7000;
    prevEn = 1'b0;
    for (int c = 0; c < 10 && !prevEn; c++) begin
      @(negedge clk);
      prevEn = mem_en;
    end
    checkOutput("postreset mem_en", 32'(prevEn), 32'd1);
    checkOutput("postreset tie to cpu", 32'(mem_addr), 32'h6000);
    mem_ack   = 1'b1;
    mem_rdata = 16'h0BAD;
    gotRdy = 1'b0;
    for (int c = 0; c < 10 && !gotRdy; c++) begin
      @(negedge clk);
      if (cpu_rdy) gotRdy = 1'b1;
    end
    checkOutput("postreset cpu_rdy", 32'(gotRdy), 32'd1);
    checkOutput("postreset cpu_rdata", 32'(cpu_rdata), 32'h0BAD);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
